// File: rtl/hs_npu_mem_responder.sv
// hs_npu_mem_responder
// Memory-side responder for the NPU line-access protocol. Serves multi-word
// line reads/writes from the NPU sequencer against a word-addressed
// scratchpad, and gives the CPU single-word backdoor access while the NPU is
// held idle. Out-of-range and misaligned NPU accesses raise a sticky error
// that clears when the NPU leaves idle to start a new job.
module hs_npu_mem_responder #(
    parameter int WORDS_PER_LINE = 2,
    parameter int MEM_WORDS      = 1024,
    parameter int READ_LATENCY   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          npu_reset_i,
    input  logic                          npu_read_ready_i,
    input  logic                          npu_write_valid_i,
    input  logic [31:0]                   npu_address_i,
    input  logic [32*WORDS_PER_LINE-1:0]  npu_wdata_i,
    output logic [32*WORDS_PER_LINE-1:0]  npu_rdata_o,
    output logic                          npu_valid_o,
    output logic                          npu_ready_o,
    input  logic                          host_req_i,
    input  logic                          host_we_i,
    input  logic [$clog2(MEM_WORDS)-1:0]  host_addr_i,
    input  logic [31:0]                   host_wdata_i,
    output logic [31:0]                   host_rdata_o,
    output logic                          host_ack_o,
    output logic                          err_o
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int LW = 32 * WORDS_PER_LINE;
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        RD_GAP,
        WR_ACK,
        HOST_WAIT,
        HOST_ACK
    } state_t;

    // Control state
    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            host_we_q;
    logic            npu_reset_q;
    logic            err_q, err_d;

    // Registered outputs
    logic            npu_valid_q, npu_valid_d;
    logic [LW-1:0]   npu_rdata_q, npu_rdata_d;
    logic            host_ack_q, host_ack_d;
    logic [31:0]     host_rdata_q, host_rdata_d;

    // Scratchpad and its read pipeline (not reset)
    logic [31:0]     mem_q [MEM_WORDS];
    logic [30:0]     rd_idx_q;
    logic [LW-1:0]   rd_pipe_q [READ_LATENCY];
    logic [LW-1:0]   rd_line;
    logic [30:0]     rd_line_idx [WORDS_PER_LINE];

    // NPU request decode
    logic [30:0]               npu_word_idx;
    logic [30:0]               npu_line_idx [WORDS_PER_LINE];
    logic [WORDS_PER_LINE-1:0] npu_inrange;
    logic                      npu_misalign;
    logic                      npu_bad;

    // FSM strobes
    logic npu_rd_fire;
    logic npu_wr_fire;
    logic host_fire;
    logic host_wr_fire;
    logic host_rd_fire;
    logic err_set;
    logic err_clr;

    assign npu_word_idx = {1'b0, npu_address_i[31:2]};
    assign npu_misalign = (npu_address_i[1:0] != 2'b00);
    assign npu_bad      = npu_misalign | ~(&npu_inrange);

    assign host_wr_fire = host_fire & host_we_i;
    assign host_rd_fire = host_fire & ~host_we_i;

    // Per-word indices of the NPU line and which of them land inside the scratchpad
    always_comb begin
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            npu_line_idx[i] = npu_word_idx + 31'(i);
            npu_inrange[i]  = (npu_line_idx[i] < 31'(MEM_WORDS));
        end
    end

    // Scratchpad read port: whole line at the captured index, out-of-range words read as zero
    always_comb begin
        rd_line = '0;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            rd_line_idx[i] = rd_idx_q + 31'(i);
            if (rd_line_idx[i] < 31'(MEM_WORDS)) begin
                rd_line[32*i +: 32] = mem_q[rd_line_idx[i][AW-1:0]];
            end
        end
    end

    // Next-state logic: abort > NPU read > NPU write > host in IDLE
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        npu_rd_fire = 1'b0;
        npu_wr_fire = 1'b0;
        host_fire   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!npu_reset_i) begin
                    if (npu_read_ready_i) begin
                        npu_rd_fire = 1'b1;
                        state_d     = RD_WAIT;
                    end else if (npu_write_valid_i) begin
                        npu_wr_fire = 1'b1;
                        state_d     = WR_ACK;
                    end
                end else if (host_req_i && !host_ack_q) begin
                    // The ack cycle overlaps IDLE; the host may still hold req then,
                    // so it must not be taken as a fresh request.
                    host_fire = 1'b1;
                    state_d   = host_we_i ? HOST_ACK : HOST_WAIT;
                end
            end
            RD_WAIT: begin
                if (npu_reset_i) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = RD_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            RD_RESP: state_d = npu_reset_i ? IDLE : RD_GAP;
            RD_GAP:  state_d = IDLE;
            WR_ACK:  state_d = IDLE;
            HOST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = HOST_ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            HOST_ACK: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Sticky error: set by any bad accepted NPU access, cleared on the idle->run edge; set wins
    always_comb begin
        err_set = (npu_rd_fire | npu_wr_fire) & npu_bad;
        err_clr = npu_reset_q & ~npu_reset_i;
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Output register next values: responses are launched on the edge leaving RD_RESP/HOST_ACK
    always_comb begin
        npu_valid_d  = (state_q == RD_RESP) && !npu_reset_i;
        npu_rdata_d  = npu_valid_d ? rd_pipe_q[READ_LATENCY-1] : npu_rdata_q;
        host_ack_d   = (state_q == HOST_ACK);
        host_rdata_d = (host_ack_d && !host_we_q) ? rd_pipe_q[READ_LATENCY-1][31:0]
                                                  : host_rdata_q;
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            host_we_q   <= 1'b0;
            npu_reset_q <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            npu_reset_q <= npu_reset_i;
            err_q       <= err_d;
            if (host_fire) begin
                host_we_q <= host_we_i;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            npu_valid_q  <= 1'b0;
            npu_rdata_q  <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            npu_valid_q  <= npu_valid_d;
            npu_rdata_q  <= npu_rdata_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // Scratchpad writes, read address capture and read latency pipeline
    always_ff @(posedge clk) begin
        if (npu_rd_fire) begin
            rd_idx_q <= npu_word_idx;
        end else if (host_rd_fire) begin
            rd_idx_q <= 31'(host_addr_i);
        end
        if (npu_wr_fire) begin
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                if (npu_inrange[i]) begin
                    mem_q[npu_line_idx[i][AW-1:0]] <= npu_wdata_i[32*i +: 32];
                end
            end
        end
        if (host_wr_fire) begin
            mem_q[host_addr_i] <= host_wdata_i;
        end
        rd_pipe_q[0] <= rd_line;
        for (int k = 1; k < READ_LATENCY; k++) begin
            rd_pipe_q[k] <= rd_pipe_q[k-1];
        end
    end

    assign npu_ready_o  = (state_q == IDLE) && !npu_reset_i && !npu_read_ready_i;
    assign npu_valid_o  = npu_valid_q;
    assign npu_rdata_o  = npu_rdata_q;
    assign host_ack_o   = host_ack_q;
    assign host_rdata_o = host_rdata_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_hs_npu_mem_responder.sv
// Directed testbench for hs_npu_mem_responder (WORDS_PER_LINE=2, MEM_WORDS=1024, READ_LATENCY=1).
module tb_hs_npu_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        npu_reset;
    logic        npu_read_ready;
    logic        npu_write_valid;
    logic [31:0] npu_address;
    logic [63:0] npu_wdata;
    logic [63:0] npu_rdata_o;
    logic        npu_valid_o;
    logic        npu_ready_o;
    logic        host_req;
    logic        host_we;
    logic [9:0]  host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata_o;
    logic        host_ack_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    int          lat;
    logic [31:0] rd;

    hs_npu_mem_responder #(
        .WORDS_PER_LINE(2),
        .MEM_WORDS(1024),
        .READ_LATENCY(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .npu_reset_i(npu_reset),
        .npu_read_ready_i(npu_read_ready),
        .npu_write_valid_i(npu_write_valid),
        .npu_address_i(npu_address),
        .npu_wdata_i(npu_wdata),
        .npu_rdata_o(npu_rdata_o),
        .npu_valid_o(npu_valid_o),
        .npu_ready_o(npu_ready_o),
        .host_req_i(host_req),
        .host_we_i(host_we),
        .host_addr_i(host_addr),
        .host_wdata_i(host_wdata),
        .host_rdata_o(host_rdata_o),
        .host_ack_o(host_ack_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Host access with NPU idle; lat = ticks from the sampling edge to ack seen, -1 on timeout
    task automatic host_access(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                               output int l, output logic [31:0] data);
        npu_reset = 1'b1;
        host_req  = 1'b0;
        tick();
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        l    = -1;
        data = '0;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (host_ack_o === 1'b1) begin
                l    = t;
                data = host_rdata_o;
                break;
            end
        end
        host_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; npu_reset = 1'b1; npu_read_ready = 1'b0; npu_write_valid = 1'b0;
        npu_address = '0; npu_wdata = '0; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (3) tick();
        checks++; if (npu_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", npu_valid_o); end
        checks++; if (npu_rdata_o !== 64'h0) begin errors++; $display("FAIL reset_rdata got=%0h exp=0", npu_rdata_o); end
        checks++; if (host_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got=%0h exp=0", host_ack_o); end
        checks++; if (host_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_hrdata got=%0h exp=0", host_rdata_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%0h exp=0", err_o); end
        checks++; if (npu_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_idle got=%0h exp=0", npu_ready_o); end
        npu_reset = 1'b0;
        #1;
        checks++; if (npu_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_run got=%0h exp=1", npu_ready_o); end
        npu_reset = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_host_preload();
        int first;
        int pulses;
        logic [63:0] line;
        host_access(1'b1, 10'd4, 32'h11223344, lat, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL host_wr_latency got=%0d exp=2", lat); end
        host_access(1'b1, 10'd5, 32'hAABBCCDD, lat, rd);
        npu_reset = 1'b0;
        tick();
        npu_address = 32'h10; npu_read_ready = 1'b1;
        first = -1; pulses = 0; line = '0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 1) begin
                npu_read_ready = 1'b0;
                #1;
                checks++; if (npu_ready_o !== 1'b0) begin errors++; $display("FAIL busy_ready got=%0h exp=0", npu_ready_o); end
            end
            if (npu_valid_o === 1'b1) begin
                pulses++;
                if (first < 0) begin first = t; line = npu_rdata_o; end
            end
        end
        checks++; if (first !== 3) begin errors++; $display("FAIL rd_latency got=%0d exp=3", first); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL rd_pulses got=%0d exp=1", pulses); end
        checks++; if (line[31:0] !== 32'h11223344) begin errors++; $display("FAIL rd_word0 got=%0h exp=11223344", line[31:0]); end
        checks++; if (line[63:32] !== 32'hAABBCCDD) begin errors++; $display("FAIL rd_word1 got=%0h exp=aabbccdd", line[63:32]); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rd_err got=%0h exp=0", err_o); end
    endtask

    task automatic test_host_stall();
        int acks;
        int first;
        npu_reset = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 10'd6; host_wdata = 32'h0000600D;
        acks = 0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (host_ack_o === 1'b1) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL stall_no_ack got=%0d exp=0", acks); end
        npu_reset = 1'b1;
        first = -1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (host_ack_o === 1'b1 && first < 0) begin first = t; host_req = 1'b0; end
        end
        host_req = 1'b0;
        checks++; if (first !== 2) begin errors++; $display("FAIL stall_release_ack got=%0d exp=2", first); end
        host_access(1'b0, 10'd6, 32'h0, lat, rd);
        checks++; if (lat !== 3) begin errors++; $display("FAIL host_rd_latency got=%0d exp=3", lat); end
        checks++; if (rd !== 32'h0000600D) begin errors++; $display("FAIL stall_data got=%0h exp=600d", rd); end
    endtask

    task automatic test_stream();
        int n;
        int last;
        logic [31:0] e0;
        for (int i = 32; i < 40; i++) host_access(1'b1, 10'(i), 32'hC0DE0000 + 32'(i), lat, rd);
        npu_reset = 1'b0;
        tick();
        npu_address = 32'h80; npu_read_ready = 1'b1;
        n = 0; last = 0;
        for (int t = 1; t <= 24; t++) begin
            tick();
            if (npu_valid_o === 1'b1) begin
                if (n < 4) begin
                    e0 = 32'hC0DE0000 + 32'(32 + 2 * n);
                    checks++; if (npu_rdata_o[31:0] !== e0) begin errors++; $display("FAIL stream_w0[%0d] got=%0h exp=%0h", n, npu_rdata_o[31:0], e0); end
                    checks++; if (npu_rdata_o[63:32] !== e0 + 32'd1) begin errors++; $display("FAIL stream_w1[%0d] got=%0h exp=%0h", n, npu_rdata_o[63:32], e0 + 32'd1); end
                    checks++; if ((t - last) !== ((n == 0) ? 3 : 4)) begin errors++; $display("FAIL stream_spacing[%0d] got=%0d exp=%0d", n, t - last, (n == 0) ? 3 : 4); end
                end
                last = t;
                n++;
                npu_address = npu_address + 32'd8;
                if (n >= 4) npu_read_ready = 1'b0;
            end
        end
        npu_read_ready = 1'b0;
        checks++; if (n !== 4) begin errors++; $display("FAIL stream_count got=%0d exp=4", n); end
    endtask

    task automatic test_npu_write();
        npu_reset = 1'b0; npu_read_ready = 1'b0; npu_write_valid = 1'b0;
        tick();
        checks++; if (npu_ready_o !== 1'b1) begin errors++; $display("FAIL wr_ready_idle got=%0h exp=1", npu_ready_o); end
        npu_address = 32'h40; npu_wdata = {32'h0000CAFE, 32'hDEADBEEF}; npu_write_valid = 1'b1;
        tick();
        npu_write_valid = 1'b0;
        #1;
        checks++; if (npu_ready_o !== 1'b0) begin errors++; $display("FAIL wr_ready_ack got=%0h exp=0", npu_ready_o); end
        tick();
        checks++; if (npu_ready_o !== 1'b1) begin errors++; $display("FAIL wr_ready_after got=%0h exp=1", npu_ready_o); end
        host_access(1'b0, 10'd16, 32'h0, lat, rd);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_word0 got=%0h exp=deadbeef", rd); end
        host_access(1'b0, 10'd17, 32'h0, lat, rd);
        checks++; if (rd !== 32'h0000CAFE) begin errors++; $display("FAIL wr_word1 got=%0h exp=cafe", rd); end
    endtask

    task automatic test_abort();
        int vcount;
        int first_ack;
        logic [31:0] hd;
        npu_reset = 1'b0;
        tick();
        npu_address = 32'h10; npu_read_ready = 1'b1;
        tick();
        npu_read_ready = 1'b0; npu_reset = 1'b1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'd5;
        vcount = 0; first_ack = -1; hd = '0;
        for (int t = 2; t <= 12; t++) begin
            tick();
            if (npu_valid_o === 1'b1) vcount++;
            if (host_ack_o === 1'b1 && first_ack < 0) begin first_ack = t; hd = host_rdata_o; host_req = 1'b0; end
        end
        host_req = 1'b0;
        checks++; if (vcount !== 0) begin errors++; $display("FAIL abort_no_valid got=%0d exp=0", vcount); end
        checks++; if (first_ack !== 5) begin errors++; $display("FAIL abort_host_ack got=%0d exp=5", first_ack); end
        checks++; if (hd !== 32'hAABBCCDD) begin errors++; $display("FAIL abort_host_data got=%0h exp=aabbccdd", hd); end
    endtask

    task automatic test_error();
        int first;
        logic [63:0] line;
        host_access(1'b1, 10'd1023, 32'h5A5A5A5A, lat, rd);
        host_access(1'b1, 10'd0, 32'h01010101, lat, rd);
        // NPU leaves idle on the same edge as an out-of-range read: the set must win
        npu_reset = 1'b0; npu_address = 32'h0000_0FFC; npu_read_ready = 1'b1;
        tick();
        npu_read_ready = 1'b0;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_set_wins got=%0h exp=1", err_o); end
        first = -1; line = '0;
        for (int t = 2; t <= 8; t++) begin
            tick();
            if (npu_valid_o === 1'b1 && first < 0) begin first = t; line = npu_rdata_o; end
        end
        checks++; if (first !== 3) begin errors++; $display("FAIL oor_rd_latency got=%0d exp=3", first); end
        checks++; if (line[31:0] !== 32'h5A5A5A5A) begin errors++; $display("FAIL oor_rd_word0 got=%0h exp=5a5a5a5a", line[31:0]); end
        checks++; if (line[63:32] !== 32'h0) begin errors++; $display("FAIL oor_rd_word1 got=%0h exp=0", line[63:32]); end
        npu_reset = 1'b1;
        repeat (3) tick();
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got=%0h exp=1", err_o); end
        npu_reset = 1'b0;
        tick();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear got=%0h exp=0", err_o); end
        npu_address = 32'h12; npu_read_ready = 1'b1;
        tick();
        npu_read_ready = 1'b0;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_misalign got=%0h exp=1", err_o); end
        first = -1; line = '0;
        for (int t = 2; t <= 8; t++) begin
            tick();
            if (npu_valid_o === 1'b1 && first < 0) begin first = t; line = npu_rdata_o; end
        end
        checks++; if (line !== {32'hAABBCCDD, 32'h11223344}) begin errors++; $display("FAIL misalign_line got=%0h exp=aabbccdd11223344", line); end
        npu_reset = 1'b1;
        tick();
        npu_reset = 1'b0;
        tick();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear2 got=%0h exp=0", err_o); end
        npu_address = 32'h0000_0FFC; npu_wdata = {32'h77777777, 32'h66666666}; npu_write_valid = 1'b1;
        tick();
        npu_write_valid = 1'b0;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_oor_write got=%0h exp=1", err_o); end
        tick();
        host_access(1'b0, 10'd0, 32'h0, lat, rd);
        checks++; if (rd !== 32'h01010101) begin errors++; $display("FAIL oor_wr_dropped got=%0h exp=01010101", rd); end
        host_access(1'b0, 10'd1023, 32'h0, lat, rd);
        checks++; if (rd !== 32'h66666666) begin errors++; $display("FAIL oor_wr_kept got=%0h exp=66666666", rd); end
    endtask

    task automatic test_rst_mid_host();
        int acks;
        npu_reset = 1'b1; host_req = 1'b0;
        tick();
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'd4;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (npu_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", npu_valid_o); end
        checks++; if (npu_rdata_o !== 64'h0) begin errors++; $display("FAIL rst_rdata got=%0h exp=0", npu_rdata_o); end
        checks++; if (host_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack got=%0h exp=0", host_ack_o); end
        checks++; if (host_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_hrdata got=%0h exp=0", host_rdata_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got=%0h exp=0", err_o); end
        host_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        acks = 0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (host_ack_o === 1'b1) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL rst_no_stale_ack got=%0d exp=0", acks); end
        host_access(1'b0, 10'd5, 32'h0, lat, rd);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rst_new_lat got=%0d exp=3", lat); end
        checks++; if (rd !== 32'hAABBCCDD) begin errors++; $display("FAIL rst_new_data got=%0h exp=aabbccdd", rd); end
    endtask

    initial begin
        test_reset();
        test_host_preload();
        test_host_stall();
        test_stream();
        test_npu_write();
        test_abort();
        test_error();
        test_rst_mid_host();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
